game_ctl_param: RTL and testbench

- Parametrised game-control FSM for the two-player ship game on BASYS3.
- Maps mouse clicks to grid cells on a configurable board and runs the ship-placement phase.
- Runs the shot/answer handshake with the link to the opponent and the incoming-shot responder.
- Tracks game-over; sits between mouse/VGA timing and the board-draw and UART-link blocks.

---
 rtl/game_ctl_param_if.sv | 14 +
 rtl/game_ctl_param.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_game_ctl_param.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctl_param_if.sv
// ---------------------------------------------------------------------------
// vga_if
// Minimal VGA timing bundle consumed by the game controller. Only the raster
// counters are carried; the controller derives its frame tick from them.
//   hcount : horizontal pixel counter
//   vcount : vertical line counter
// ---------------------------------------------------------------------------
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;

    modport in  (input  hcount, input  vcount);
    modport out (output hcount, output vcount);
endinterface

// File: rtl/game_ctl_param.sv
// ---------------------------------------------------------------------------
// game_ctl_param
// Game-control FSM for the two-player ship game. Turns mouse clicks into grid
// cells, runs ship placement, the outgoing shot / answer handshake with the
// opponent link, answers incoming shots, and tracks the end of the game.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   vga_in          : raster timing, frame tick when hcount==0 && vcount==0
//   mouse_left      : left button level
//   mouse_xpos/ypos : pointer position in pixels
//   peer_ready      : opponent finished placing
//   start_first     : we shoot first (sampled when leaving READY)
//   answer          : reply to our shot, 01 miss, 10 hit, 11 reject
//   shot_in_valid   : opponent shot present (one-cycle pulse)
//   shot_in         : opponent shot {row, col}
//   cell_pos        : last valid clicked cell {row, col}
//   place_req       : pulse, place a ship at cell_pos
//   shot_out        : our pending shot
//   shot_valid      : held while waiting for an answer
//   reply_valid     : pulse answering shot_in, reply holds until next one
//   reply           : 01 miss, 10 hit, 11 invalid
//   timeout_err     : pulse when an answer never arrived
//   state_out       : current state encoding
//   ships_placed    : number of ship cells placed so far
//   game_over, win  : game finished, and whether we won
// ---------------------------------------------------------------------------
module game_ctl_param #(
    parameter int GRID_N     = 10,
    parameter int CELL_LOG2  = 5,
    parameter int BOARD_X0   = 608,
    parameter int BOARD_Y0   = 193,
    parameter int SHIPS      = 10,
    parameter int TIMEOUT_FR = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    vga_if.in                          vga_in,
    input  logic                       mouse_left,
    input  logic [11:0]                mouse_xpos,
    input  logic [11:0]                mouse_ypos,
    input  logic                       peer_ready,
    input  logic                       start_first,
    input  logic [1:0]                 answer,
    input  logic                       shot_in_valid,
    input  logic [7:0]                 shot_in,
    output logic [7:0]                 cell_pos,
    output logic                       place_req,
    output logic [7:0]                 shot_out,
    output logic                       shot_valid,
    output logic                       reply_valid,
    output logic [1:0]                 reply,
    output logic                       timeout_err,
    output logic [2:0]                 state_out,
    output logic [$clog2(SHIPS+1)-1:0] ships_placed,
    output logic                       game_over,
    output logic                       win
);

    localparam int CELLS    = GRID_N * GRID_N;
    localparam int IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CNT_W    = $clog2(SHIPS + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_FR + 1);
    localparam int BOARD_PX = GRID_N << CELL_LOG2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PLACE      = 3'd1,
        S_READY      = 3'd2,
        S_MY_TURN    = 3'd3,
        S_WAIT_ANS   = 3'd4,
        S_THEIR_TURN = 3'd5,
        S_OVER       = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               mouseLeft_q;
    logic [7:0]         cellPos_q, cellPos_d;
    logic               placeReq_q, placeReq_d;
    logic [7:0]         shotOut_q, shotOut_d;
    logic               shotValid_q, shotValid_d;
    logic               replyValid_q, replyValid_d;
    logic [1:0]         reply_q, reply_d;
    logic               timeoutErr_q, timeoutErr_d;
    logic [CNT_W-1:0]   placed_q, placed_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [CNT_W-1:0]   lost_q, lost_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CELLS-1:0]   occ_q, occ_d;
    logic [CELLS-1:0]   shot_q, shot_d;
    logic [CELLS-1:0]   hit_q, hit_d;
    logic               gameOver_q, gameOver_d;
    logic               win_q, win_d;

    int                 xRel;
    int                 yRel;
    logic               click;
    logic               validClick;
    logic [3:0]         clickRow;
    logic [3:0]         clickCol;
    logic [IDX_W-1:0]   clickIdx;
    logic [IDX_W-1:0]   shotIdx;
    logic [IDX_W-1:0]   inIdx;
    logic               inOnBoard;
    logic               frameTick;

    // Pointer-to-cell decode. Offsets are signed so that pointers left of or
    // above the board come out negative and fail the range test.
    always_comb begin
        frameTick  = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
        click      = mouse_left && !mouseLeft_q;
        xRel       = int'(mouse_xpos) - BOARD_X0;
        yRel       = int'(mouse_ypos) - BOARD_Y0;
        validClick = click && (xRel >= 0) && (xRel < BOARD_PX)
                           && (yRel >= 0) && (yRel < BOARD_PX);
        clickCol   = 4'(xRel >>> CELL_LOG2);
        clickRow   = 4'(yRel >>> CELL_LOG2);
        clickIdx   = IDX_W'(int'(clickRow) * GRID_N + int'(clickCol));
        shotIdx    = IDX_W'(int'(shotOut_q[7:4]) * GRID_N + int'(shotOut_q[3:0]));
        inIdx      = IDX_W'(int'(shot_in[7:4]) * GRID_N + int'(shot_in[3:0]));
        inOnBoard  = (int'(shot_in[7:4]) < GRID_N) && (int'(shot_in[3:0]) < GRID_N);
    end

    // Next-state and output logic. Pulses default low; everything else holds.
    always_comb begin
        state_d      = state_q;
        cellPos_d    = cellPos_q;
        placeReq_d   = 1'b0;
        shotOut_d    = shotOut_q;
        shotValid_d  = shotValid_q;
        replyValid_d = 1'b0;
        reply_d      = reply_q;
        timeoutErr_d = 1'b0;
        placed_d     = placed_q;
        hits_d       = hits_q;
        lost_d       = lost_q;
        tmo_d        = tmo_q;
        occ_d        = occ_q;
        shot_d       = shot_q;
        hit_d        = hit_q;
        gameOver_d   = gameOver_q;
        win_d        = win_q;

        // cell_pos follows every on-board click until the game is over
        if (validClick && state_q != S_OVER) begin
            cellPos_d = {clickRow, clickCol};
        end

        case (state_q)
            S_IDLE: begin
                if (click) begin
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                if (placed_q == CNT_W'(SHIPS)) begin
                    state_d = S_READY;
                end else if (validClick && !occ_q[clickIdx]) begin
                    occ_d[clickIdx] = 1'b1;
                    placeReq_d      = 1'b1;
                    placed_d        = placed_q + 1'b1;
                end
            end
            S_READY: begin
                if (peer_ready) begin
                    state_d = start_first ? S_MY_TURN : S_THEIR_TURN;
                end
            end
            S_MY_TURN: begin
                if (validClick && !shot_q[clickIdx]) begin
                    shotOut_d   = {clickRow, clickCol};
                    shotValid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_WAIT_ANS;
                end
            end
            S_WAIT_ANS: begin
                // An answer wins over a frame tick arriving in the same cycle
                case (answer)
                    2'b01: begin
                        shot_d[shotIdx] = 1'b1;
                        shotValid_d     = 1'b0;
                        state_d         = S_THEIR_TURN;
                    end
                    2'b10: begin
                        shot_d[shotIdx] = 1'b1;
                        hits_d          = hits_q + 1'b1;
                        shotValid_d     = 1'b0;
                        if (hits_d == CNT_W'(SHIPS)) begin
                            state_d    = S_OVER;
                            gameOver_d = 1'b1;
                            win_d      = 1'b1;
                        end else begin
                            state_d = S_MY_TURN;
                        end
                    end
                    2'b11: begin
                        shotValid_d = 1'b0;
                        state_d     = S_MY_TURN;
                    end
                    default: begin
                        if (frameTick) begin
                            tmo_d = tmo_q + 1'b1;
                            if (tmo_d == TMO_W'(TIMEOUT_FR)) begin
                                timeoutErr_d = 1'b1;
                                shotValid_d  = 1'b0;
                                state_d      = S_MY_TURN;
                            end
                        end
                    end
                endcase
            end
            S_THEIR_TURN: begin
                if (shot_in_valid) begin
                    replyValid_d = 1'b1;
                    if (!inOnBoard) begin
                        reply_d = 2'b11;
                    end else if (occ_q[inIdx] && !hit_q[inIdx]) begin
                        reply_d       = 2'b10;
                        hit_d[inIdx]  = 1'b1;
                        lost_d        = lost_q + 1'b1;
                        if (lost_d == CNT_W'(SHIPS)) begin
                            state_d    = S_OVER;
                            gameOver_d = 1'b1;
                            win_d      = 1'b0;
                        end
                    end else begin
                        reply_d = 2'b01;
                        state_d = S_MY_TURN;
                    end
                end
            end
            S_OVER: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears the whole game.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mouseLeft_q  <= 1'b0;
            cellPos_q    <= '0;
            placeReq_q   <= 1'b0;
            shotOut_q    <= '0;
            shotValid_q  <= 1'b0;
            replyValid_q <= 1'b0;
            reply_q      <= '0;
            timeoutErr_q <= 1'b0;
            placed_q     <= '0;
            hits_q       <= '0;
            lost_q       <= '0;
            tmo_q        <= '0;
            occ_q        <= '0;
            shot_q       <= '0;
            hit_q        <= '0;
            gameOver_q   <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mouseLeft_q  <= mouse_left;
            cellPos_q    <= cellPos_d;
            placeReq_q   <= placeReq_d;
            shotOut_q    <= shotOut_d;
            shotValid_q  <= shotValid_d;
            replyValid_q <= replyValid_d;
            reply_q      <= reply_d;
            timeoutErr_q <= timeoutErr_d;
            placed_q     <= placed_d;
            hits_q       <= hits_d;
            lost_q       <= lost_d;
            tmo_q        <= tmo_d;
            occ_q        <= occ_d;
            shot_q       <= shot_d;
            hit_q        <= hit_d;
            gameOver_q   <= gameOver_d;
            win_q        <= win_d;
        end
    end

    assign cell_pos     = cellPos_q;
    assign place_req    = placeReq_q;
    assign shot_out     = shotOut_q;
    assign shot_valid   = shotValid_q;
    assign reply_valid  = replyValid_q;
    assign reply        = reply_q;
    assign timeout_err  = timeoutErr_q;
    assign state_out    = state_q;
    assign ships_placed = placed_q;
    assign game_over    = gameOver_q;
    assign win          = win_q;

endmodule

// File: tb/tb_game_ctl_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_game_ctl_param
// Directed game scenarios plus a long randomized game, all compared against a
// behavioural model of the game rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_game_ctl_param;

    localparam int GRID_N = 10;
    localparam int SHIPS  = 10;
    localparam int TMO    = 120;
    localparam int X0     = 608;
    localparam int Y0     = 193;
    localparam int CELL   = 32;
    localparam int M_IDLE = 0, M_PLACE = 1, M_READY = 2, M_MY = 3;
    localparam int M_WAIT = 4, M_THEIR = 5, M_OVER = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        peer_ready = 1'b0;
    logic        start_first = 1'b0;
    logic [1:0]  answer = 2'b00;
    logic        shot_in_valid = 1'b0;
    logic [7:0]  shot_in = '0;
    logic [7:0]  cell_pos;
    logic        place_req;
    logic [7:0]  shot_out;
    logic        shot_valid;
    logic        reply_valid;
    logic [1:0]  reply;
    logic        timeout_err;
    logic [2:0]  state_out;
    logic [3:0]  ships_placed;
    logic        game_over;
    logic        win;

    vga_if vgaBus();

    game_ctl_param #(
        .GRID_N(GRID_N), .CELL_LOG2(5), .BOARD_X0(X0), .BOARD_Y0(Y0),
        .SHIPS(SHIPS), .TIMEOUT_FR(TMO)
    ) dut (
        .clk(clk), .rst(rst), .vga_in(vgaBus),
        .mouse_left(mouse_left), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .peer_ready(peer_ready), .start_first(start_first), .answer(answer),
        .shot_in_valid(shot_in_valid), .shot_in(shot_in),
        .cell_pos(cell_pos), .place_req(place_req), .shot_out(shot_out),
        .shot_valid(shot_valid), .reply_valid(reply_valid), .reply(reply),
        .timeout_err(timeout_err), .state_out(state_out),
        .ships_placed(ships_placed), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    // Behavioural model of the game: plain counters and per-cell flags
    int         mState;
    bit         mOcc [GRID_N*GRID_N];
    bit         mShot[GRID_N*GRID_N];
    bit         mHit [GRID_N*GRID_N];
    int         mPlaced, mHits, mLost, mTmo;
    bit         mPrevLeft;
    logic [7:0] mCellPos, mShotOut;
    logic [1:0] mReply;
    bit         mPlaceReq, mShotValid, mReplyValid, mTmoErr, mGameOver, mWin;

    int nVec = 0;
    int nErr = 0;

    function automatic void modelReset();
        mState = M_IDLE;
        foreach (mOcc[i]) begin
            mOcc[i] = 0; mShot[i] = 0; mHit[i] = 0;
        end
        mPlaced = 0; mHits = 0; mLost = 0; mTmo = 0; mPrevLeft = 0;
        mCellPos = '0; mShotOut = '0; mReply = '0;
        mPlaceReq = 0; mShotValid = 0; mReplyValid = 0; mTmoErr = 0;
        mGameOver = 0; mWin = 0;
    endfunction

    // One clock of game rules, applied to the inputs present at the edge
    function automatic void modelStep();
        bit clickEv, onB;
        int xr, yr, r, c, idx, sIdx, ir, ic;
        if (rst) begin
            modelReset();
            return;
        end
        clickEv   = mouse_left && !mPrevLeft;
        mPrevLeft = mouse_left;
        xr  = int'(mouse_xpos) - X0;
        yr  = int'(mouse_ypos) - Y0;
        onB = clickEv && xr >= 0 && xr < GRID_N * CELL && yr >= 0 && yr < GRID_N * CELL;
        c   = onB ? xr / CELL : 0;
        r   = onB ? yr / CELL : 0;
        idx = r * GRID_N + c;
        sIdx = int'(mShotOut[7:4]) * GRID_N + int'(mShotOut[3:0]);
        mPlaceReq = 0; mReplyValid = 0; mTmoErr = 0;
        if (onB && mState != M_OVER) mCellPos = {4'(r), 4'(c)};
        case (mState)
            M_IDLE:  if (clickEv) mState = M_PLACE;
            M_PLACE: begin
                if (mPlaced == SHIPS) mState = M_READY;
                else if (onB && !mOcc[idx]) begin
                    mOcc[idx] = 1; mPlaceReq = 1; mPlaced++;
                end
            end
            M_READY: if (peer_ready) mState = start_first ? M_MY : M_THEIR;
            M_MY: begin
                if (onB && !mShot[idx]) begin
                    mShotOut = {4'(r), 4'(c)}; mShotValid = 1; mTmo = 0; mState = M_WAIT;
                end
            end
            M_WAIT: begin
                if (answer == 2'b01) begin
                    mShot[sIdx] = 1; mShotValid = 0; mState = M_THEIR;
                end else if (answer == 2'b10) begin
                    mShot[sIdx] = 1; mShotValid = 0; mHits++;
                    if (mHits == SHIPS) begin
                        mState = M_OVER; mGameOver = 1; mWin = 1;
                    end else mState = M_MY;
                end else if (answer == 2'b11) begin
                    mShotValid = 0; mState = M_MY;
                end else if (vgaBus.hcount == 0 && vgaBus.vcount == 0) begin
                    mTmo++;
                    if (mTmo == TMO) begin
                        mTmoErr = 1; mShotValid = 0; mState = M_MY;
                    end
                end
            end
            M_THEIR: begin
                if (shot_in_valid) begin
                    ir = int'(shot_in[7:4]); ic = int'(shot_in[3:0]);
                    mReplyValid = 1;
                    if (ir >= GRID_N || ic >= GRID_N) mReply = 2'b11;
                    else if (mOcc[ir*GRID_N+ic] && !mHit[ir*GRID_N+ic]) begin
                        mReply = 2'b10; mHit[ir*GRID_N+ic] = 1; mLost++;
                        if (mLost == SHIPS) begin
                            mState = M_OVER; mGameOver = 1; mWin = 0;
                        end
                    end else begin
                        mReply = 2'b01; mState = M_MY;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [30:0] dutVec();
        return {state_out, cell_pos, place_req, shot_out, shot_valid, reply_valid,
                reply, timeout_err, ships_placed, game_over, win};
    endfunction

    function automatic logic [30:0] modelVec();
        return {3'(mState), mCellPos, mPlaceReq, mShotOut, mShotValid, mReplyValid,
                mReply, mTmoErr, 4'(mPlaced), mGameOver, mWin};
    endfunction

    function automatic int cx(input int c);
        return X0 + CELL * c + 5;
    endfunction

    function automatic int cy(input int r);
        return Y0 + CELL * r + 5;
    endfunction

    // Stimulus tasks: drive, clock, advance the model; no checking here
    task automatic tick1();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic applyClick(input int x, input int y);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y);
        mouse_left = 1'b0; tick1();
        mouse_left = 1'b1; tick1();
        mouse_left = 1'b0;
    endtask

    task automatic applyAnswer(input logic [1:0] a);
        answer = a; tick1(); answer = 2'b00;
    endtask

    task automatic applyShot(input logic [7:0] s);
        shot_in = s; shot_in_valid = 1'b1; tick1(); shot_in_valid = 1'b0;
    endtask

    task automatic applyFrame();
        vgaBus.hcount = 11'd0; vgaBus.vcount = 11'd0; tick1();
        vgaBus.hcount = 11'd1; vgaBus.vcount = 11'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idleCycles(2);
        nVec++;
        if (dutVec() !== 31'd0) begin
            nErr++; $display("[TB] FAIL reset_outputs: got %h want 0", dutVec());
        end
        rst = 1'b0;
    endtask

    task automatic test_place();
        applyClick(620, 200);
        nVec++;
        if (state_out !== 3'd1 || ships_placed !== 4'd0 || place_req !== 1'b0) begin
            nErr++; $display("[TB] FAIL idle_to_place: st=%0d cnt=%0d req=%b want 1/0/0", state_out, ships_placed, place_req);
        end
        applyClick(620, 200);
        nVec++;
        if (cell_pos !== 8'h00 || place_req !== 1'b1 || ships_placed !== 4'd1) begin
            nErr++; $display("[TB] FAIL place_first: cell=%h req=%b cnt=%0d want 00/1/1", cell_pos, place_req, ships_placed);
        end
        idleCycles(1);
        nVec++;
        if (place_req !== 1'b0) begin
            nErr++; $display("[TB] FAIL place_pulse_len: req=%b want 0", place_req);
        end
        applyClick(620, 200);
        nVec++;
        if (place_req !== 1'b0 || ships_placed !== 4'd1) begin
            nErr++; $display("[TB] FAIL place_occupied: req=%b cnt=%0d want 0/1", place_req, ships_placed);
        end
        applyClick(600, 200);
        applyClick(928, 200);
        nVec++;
        if (cell_pos !== 8'h00 || ships_placed !== 4'd1 || dutVec() !== modelVec()) begin
            nErr++; $display("[TB] FAIL offboard_click: dut=%h model=%h", dutVec(), modelVec());
        end
        applyClick(927, 480);
        nVec++;
        if (cell_pos !== 8'h89 || place_req !== 1'b1 || ships_placed !== 4'd2) begin
            nErr++; $display("[TB] FAIL corner_cell: cell=%h req=%b cnt=%0d want 89/1/2", cell_pos, place_req, ships_placed);
        end
    endtask

    task automatic test_turns();
        for (int r = 1; r <= 8; r++) begin
            applyClick(cx(0), cy(r));
            nVec++;
            if (dutVec() !== modelVec()) begin
                nErr++; $display("[TB] FAIL place_row%0d: dut=%h model=%h", r, dutVec(), modelVec());
            end
        end
        idleCycles(1);
        nVec++;
        if (state_out !== 3'd2 || ships_placed !== 4'd10) begin
            nErr++; $display("[TB] FAIL to_ready: st=%0d cnt=%0d want 2/10", state_out, ships_placed);
        end
        peer_ready = 1'b1; start_first = 1'b1; tick1();
        nVec++;
        if (state_out !== 3'd3) begin
            nErr++; $display("[TB] FAIL ready_to_my: st=%0d want 3", state_out);
        end
        applyClick(cx(3), cy(2));
        nVec++;
        if (state_out !== 3'd4 || shot_valid !== 1'b1 || shot_out !== 8'h23) begin
            nErr++; $display("[TB] FAIL shoot_23: st=%0d sv=%b so=%h want 4/1/23", state_out, shot_valid, shot_out);
        end
        applyAnswer(2'b10);
        nVec++;
        if (state_out !== 3'd3 || shot_valid !== 1'b0) begin
            nErr++; $display("[TB] FAIL hit_again: st=%0d sv=%b want 3/0", state_out, shot_valid);
        end
        applyClick(cx(4), cy(2));
        applyAnswer(2'b01);
        nVec++;
        if (state_out !== 3'd5 || dutVec() !== modelVec()) begin
            nErr++; $display("[TB] FAIL miss_to_their: dut=%h model=%h", dutVec(), modelVec());
        end
    endtask

    task automatic test_their_turn();
        applyShot(8'h00);
        nVec++;
        if (reply_valid !== 1'b1 || reply !== 2'b10 || state_out !== 3'd5) begin
            nErr++; $display("[TB] FAIL incoming_hit: rv=%b r=%b st=%0d want 1/10/5", reply_valid, reply, state_out);
        end
        idleCycles(1);
        nVec++;
        if (reply_valid !== 1'b0 || reply !== 2'b10) begin
            nErr++; $display("[TB] FAIL reply_hold: rv=%b r=%b want 0/10", reply_valid, reply);
        end
        applyShot(8'h00);
        nVec++;
        if (reply !== 2'b01 || state_out !== 3'd3) begin
            nErr++; $display("[TB] FAIL repeat_shot_miss: r=%b st=%0d want 01/3", reply, state_out);
        end
        applyShot(8'h00);
        nVec++;
        if (reply_valid !== 1'b0 || dutVec() !== modelVec()) begin
            nErr++; $display("[TB] FAIL shot_outside_their: dut=%h model=%h", dutVec(), modelVec());
        end
        applyClick(cx(5), cy(2));
        applyAnswer(2'b01);
        applyShot(8'hA0);
        nVec++;
        if (reply !== 2'b11 || reply_valid !== 1'b1 || state_out !== 3'd5) begin
            nErr++; $display("[TB] FAIL offboard_shot: r=%b rv=%b st=%0d want 11/1/5", reply, reply_valid, state_out);
        end
        applyShot(8'h09);
        nVec++;
        if (reply !== 2'b01 || state_out !== 3'd3) begin
            nErr++; $display("[TB] FAIL empty_cell_miss: r=%b st=%0d want 01/3", reply, state_out);
        end
    endtask

    task automatic test_timeout();
        applyClick(cx(6), cy(2));
        for (int i = 0; i < TMO - 1; i++) applyFrame();
        applyClick(cx(7), cy(2));
        nVec++;
        if (state_out !== 3'd4 || timeout_err !== 1'b0 || shot_out !== 8'h26) begin
            nErr++; $display("[TB] FAIL before_timeout: st=%0d te=%b so=%h want 4/0/26", state_out, timeout_err, shot_out);
        end
        applyFrame();
        nVec++;
        if (timeout_err !== 1'b1 || shot_valid !== 1'b0 || state_out !== 3'd3) begin
            nErr++; $display("[TB] FAIL timeout_fire: te=%b sv=%b st=%0d want 1/0/3", timeout_err, shot_valid, state_out);
        end
        idleCycles(1);
        applyClick(cx(6), cy(2));
        nVec++;
        if (state_out !== 3'd4 || shot_valid !== 1'b1 || timeout_err !== 1'b0) begin
            nErr++; $display("[TB] FAIL reshoot_after_timeout: st=%0d sv=%b te=%b want 4/1/0", state_out, shot_valid, timeout_err);
        end
        applyAnswer(2'b10);
    endtask

    task automatic test_win();
        for (int c = 0; c < 8; c++) begin
            applyClick(cx(c), cy(5));
            applyAnswer(2'b10);
            nVec++;
            if (dutVec() !== modelVec()) begin
                nErr++; $display("[TB] FAIL hit_seq%0d: dut=%h model=%h", c, dutVec(), modelVec());
            end
        end
        nVec++;
        if (state_out !== 3'd6 || game_over !== 1'b1 || win !== 1'b1) begin
            nErr++; $display("[TB] FAIL win_over: st=%0d go=%b win=%b want 6/1/1", state_out, game_over, win);
        end
        applyClick(cx(9), cy(9));
        applyShot(8'h00);
        applyAnswer(2'b01);
        nVec++;
        if (state_out !== 3'd6 || reply_valid !== 1'b0 || cell_pos !== 8'h57 || dutVec() !== modelVec()) begin
            nErr++; $display("[TB] FAIL over_ignores_inputs: dut=%h model=%h", dutVec(), modelVec());
        end
        rst = 1'b1; tick1(); rst = 1'b0;
        nVec++;
        if (dutVec() !== 31'd0) begin
            nErr++; $display("[TB] FAIL reset_from_over: got %h want 0", dutVec());
        end
    endtask

    task automatic test_lose();
        logic [7:0] cells [10];
        for (int r = 0; r < 9; r++) cells[r] = {4'(r), 4'd0};
        cells[9] = 8'h89;
        start_first = 1'b0;
        applyClick(cx(0), cy(0));
        for (int i = 0; i < 10; i++) applyClick(cx(int'(cells[i][3:0])), cy(int'(cells[i][7:4])));
        idleCycles(1);
        tick1();
        nVec++;
        if (state_out !== 3'd5 || ships_placed !== 4'd10) begin
            nErr++; $display("[TB] FAIL lose_setup: st=%0d cnt=%0d want 5/10", state_out, ships_placed);
        end
        for (int i = 0; i < 10; i++) begin
            applyShot(cells[i]);
            nVec++;
            if (reply !== 2'b10 || dutVec() !== modelVec()) begin
                nErr++; $display("[TB] FAIL incoming_seq%0d: dut=%h model=%h", i, dutVec(), modelVec());
            end
        end
        nVec++;
        if (state_out !== 3'd6 || game_over !== 1'b1 || win !== 1'b0) begin
            nErr++; $display("[TB] FAIL lose_over: st=%0d go=%b win=%b want 6/1/0", state_out, game_over, win);
        end
        rst = 1'b1; tick1(); rst = 1'b0;
    endtask

    task automatic test_random();
        int overCnt = 0;
        for (int i = 0; i < 6000; i++) begin
            rst           = (mState == M_OVER && overCnt > 15) || ($urandom_range(0, 999) == 0);
            mouse_left    = 1'($urandom_range(0, 1));
            mouse_xpos    = 12'(600 + $urandom_range(0, 339));
            mouse_ypos    = 12'(185 + $urandom_range(0, 339));
            peer_ready    = ($urandom_range(0, 3) != 0);
            start_first   = 1'($urandom_range(0, 1));
            answer        = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            shot_in_valid = ($urandom_range(0, 2) == 0);
            shot_in       = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            if ($urandom_range(0, 3) == 0) begin
                vgaBus.hcount = 11'd0; vgaBus.vcount = 11'd0;
            end else begin
                vgaBus.hcount = 11'd1; vgaBus.vcount = 11'd1;
            end
            tick1();
            nVec++;
            if (dutVec() !== modelVec()) begin
                nErr++; $display("[TB] FAIL random_cycle%0d: dut=%h model=%h", i, dutVec(), modelVec());
            end
            overCnt = (mState == M_OVER) ? overCnt + 1 : 0;
        end
        rst = 1'b0; mouse_left = 1'b0; answer = 2'b00; shot_in_valid = 1'b0;
        vgaBus.hcount = 11'd1; vgaBus.vcount = 11'd1;
    endtask

    initial begin
        vgaBus.hcount = 11'd1;
        vgaBus.vcount = 11'd1;
        modelReset();
        test_reset();
        test_place();
        test_turns();
        test_their_turn();
        test_timeout();
        test_win();
        test_lose();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
